// File: rtl/stream_word_packer_if.sv
// Valid/ready stream bundle shared by packer input and output.
// Ports: tdata, tkeep, tlast, tvalid (source side), tready (sink side).
interface stream_word_packer_if #(
  parameter int DW = 32,
  parameter int KW = 1
);
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tkeep,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/stream_word_packer.sv
// Packs NWORDS narrow words into one wide beat; TLAST closes short beats.
// Ports: CLK, RST (sync, high), s_axis (word in), m_axis (beat + keep out).
module stream_word_packer #(
  parameter int WORD_WIDTH = 32,
  parameter int NWORDS     = 7
) (
  input  logic CLK,
  input  logic RST,
  stream_word_packer_if.slave  s_axis,
  stream_word_packer_if.master m_axis
);
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int DW = WORD_WIDTH * NWORDS;
  localparam logic [CW-1:0] LAST_SLOT = CW'(NWORDS - 1);

  logic [NWORDS-2:0][WORD_WIDTH-1:0] acc;
  logic [CW-1:0]                     cnt;

  logic [DW-1:0]     m_data;
  logic [NWORDS-1:0] m_keep;
  logic              m_last;
  logic              m_valid;

  logic              s_ready;
  logic              take;
  logic              close;
  logic [DW-1:0]     beat_data;
  logic [NWORDS-1:0] beat_keep;

  // Accept only when the output register can take a new beat
  // this cycle, so a stalled beat freezes the accumulator too.
  assign s_ready = !RST && (!m_valid || m_axis.tready);
  assign take    = s_axis.tvalid && s_ready;
  assign close   = take && (s_axis.tlast || cnt == LAST_SLOT);

  always_comb begin
    beat_data = '0;
    beat_keep = '0;
    for (int i = 0; i < NWORDS - 1; i++) begin
      if (CW'(i) < cnt)
        beat_data[i*WORD_WIDTH +: WORD_WIDTH] = acc[i];
    end
    for (int i = 0; i < NWORDS; i++) begin
      if (CW'(i) == cnt)
        beat_data[i*WORD_WIDTH +: WORD_WIDTH] = s_axis.tdata;
      beat_keep[i] = (CW'(i) <= cnt);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc     <= '0;
      cnt     <= '0;
      m_data  <= '0;
      m_keep  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      if (m_valid && m_axis.tready)
        m_valid <= 1'b0;
      // A load overrides the release above: back-to-back beats
      // go out with no bubble.
      if (close) begin
        m_data  <= beat_data;
        m_keep  <= beat_keep;
        m_last  <= s_axis.tlast;
        m_valid <= 1'b1;
        cnt     <= '0;
        acc     <= '0;
      end else if (take) begin
        acc[cnt] <= s_axis.tdata;
        cnt      <= cnt + 1'b1;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tdata  = m_data;
  assign m_axis.tkeep  = m_keep;
  assign m_axis.tlast  = m_last;
  assign m_axis.tvalid = m_valid;
endmodule

// File: tb/tb_stream_word_packer.sv
// Scoreboard bench for stream_word_packer.
// Directed groups push expected beats; a negedge monitor checks them.
module tb_stream_word_packer;
  localparam int WW = 32;
  localparam int NW = 7;
  localparam int DW = WW * NW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [NW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_word_packer_if #(.DW(WW), .KW(1)) s_axis ();
  stream_word_packer_if #(.DW(DW), .KW(NW)) m_axis ();

  stream_word_packer #(
    .WORD_WIDTH(WW),
    .NWORDS(NW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .s_axis(s_axis.slave),
    .m_axis(m_axis.master)
  );

  int errors = 0;
  int checks = 0;
  beat_t exp_q[$];
  beat_t e;
  beat_t held;
  bit    held_v = 1'b0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic void push_seq(input logic [WW-1:0] base,
                                   input int n,
                                   input logic [NW-1:0] keep,
                                   input logic last);
    beat_t b;
    b.data = '0;
    for (int i = 0; i < n; i++)
      b.data[i*WW +: WW] = base + 32'(i);
    b.keep = keep;
    b.last = last;
    exp_q.push_back(b);
  endfunction

  // Monitor: inputs change only at posedge+1, so the negedge
  // view is what the next posedge will see.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h keep %h",
                   m_axis.tdata, m_axis.tkeep);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", m_axis.tdata, e.data);
          chk("beat_keep", DW'(m_axis.tkeep), DW'(e.keep));
          chk("beat_last", DW'(m_axis.tlast), DW'(e.last));
        end
      end
      if (m_axis.tvalid && !m_axis.tready) begin
        chk("stall_s_ready", DW'(s_axis.tready), '0);
        if (held_v) begin
          chk("stall_data", m_axis.tdata, held.data);
          chk("stall_keep", DW'(m_axis.tkeep), DW'(held.keep));
          chk("stall_last", DW'(m_axis.tlast), DW'(held.last));
        end
        held_v    = 1'b1;
        held.data = m_axis.tdata;
        held.keep = m_axis.tkeep;
        held.last = m_axis.tlast;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic send(input logic [WW-1:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    s_axis.tvalid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = s_axis.tready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %h not accepted, required accept", d);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 32'hDEAD_BEEF;
    s_axis.tlast  = 1'b0;
    s_axis.tkeep  = 1'b1;
    m_axis.tready = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("rst_tvalid", DW'(m_axis.tvalid), '0);
      chk("rst_tdata", m_axis.tdata, '0);
      chk("rst_tkeep", DW'(m_axis.tkeep), '0);
      chk("rst_tlast", DW'(m_axis.tlast), '0);
      chk("rst_s_ready", DW'(s_axis.tready), '0);
    end
    @(posedge clk);
    #1;
    rst           = 1'b0;
    s_axis.tvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", DW'(s_axis.tready), DW'(1));
    @(posedge clk);
    #1;

    // Full beat 1..7
    push_seq(32'h1, 7, 7'h7F, 1'b0);
    for (int i = 1; i <= 7; i++) send(32'(i), 1'b0);

    // Short packet A,B,C then full 1..7
    push_seq(32'hA, 3, 7'h07, 1'b1);
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    push_seq(32'h1, 7, 7'h7F, 1'b0);
    for (int i = 1; i <= 7; i++) send(32'(i), 1'b0);

    // Single-word packet
    push_seq(32'h55, 1, 7'h01, 1'b1);
    send(32'h55, 1'b1);
    idle(3);

    // Backpressure: stall 5 cycles after first TVALID
    push_seq(32'h1, 7, 7'h7F, 1'b0);
    push_seq(32'h8, 7, 7'h7F, 1'b0);
    m_axis.tready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 14; i++) send(32'(i), 1'b0);
      end
      begin
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
          @(negedge clk);
          seen = m_axis.tvalid;
        end
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL bp_wait: tvalid 0, required 1");
        end
        repeat (5) @(posedge clk);
        #1;
        m_axis.tready = 1'b1;
      end
    join
    idle(3);

    // Reset mid-group discards 1..4
    for (int i = 1; i <= 4; i++) send(32'(i), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_seq(32'h10, 7, 7'h7F, 1'b0);
    for (int i = 0; i < 7; i++) send(32'h10 + 32'(i), 1'b0);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) idle(1);
    idle(3);
    chk("queue_empty", DW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
